// File: rtl/full_adder_16bit_pkg.sv
// Shared constants for the 16-bit ripple adder.
// Holds the default width, reset value and overflow helper.
package full_adder_16bit_pkg;

   localparam int FA_WIDTH = 16;

   // Registered outputs reset to all zeros.
   localparam logic FA_RST_BIT = 1'b0;

   // Signed overflow: carry into MSB differs from carry out of MSB.
   function automatic logic signed_ovf(
      input logic c_into_msb,
      input logic c_out_msb
   );
      return c_into_msb ^ c_out_msb;
   endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell.
// One stage of the ripple-carry chain.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   // Sum and majority carry for one bit.
   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/full_adder_16bit.sv
// Ripple-carry adder with combinational and registered results.
// Registered side also carries a signed-overflow flag.
module full_adder_16bit
   import full_adder_16bit_pkg::*;
#(
   parameter int WIDTH = FA_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] sum_q,
   output logic             cout_q,
   output logic             ovf_q
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      full_adder_1bit u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[WIDTH];

   // Next-state values for the output register.
   always_comb begin
      sum_d  = sum;
      cout_d = cout;
      ovf_d  = signed_ovf(c[WIDTH-1], c[WIDTH]);
   end

   // Capture results each edge; async reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= {WIDTH{FA_RST_BIT}};
         cout_q <= FA_RST_BIT;
         ovf_q  <= FA_RST_BIT;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule

// File: tb/tb_full_adder_16bit.sv
// Self-checking bench for full_adder_16bit.
// Directed vectors, reset cases, random and clockless phases.
module tb_full_adder_16bit;

   logic        clk = 1'b0;
   logic        clk_en = 1'b1;
   logic        rst_n;
   logic [15:0] a, b;
   logic        cin;
   logic [15:0] sum, sum_q;
   logic        cout, cout_q, ovf_q;

   int passed = 0;
   int total  = 0;

   full_adder_16bit dut (
      .a      (a),
      .b      (b),
      .cin    (cin),
      .sum    (sum),
      .cout   (cout),
      .clk    (clk),
      .rst_n  (rst_n),
      .sum_q  (sum_q),
      .cout_q (cout_q),
      .ovf_q  (ovf_q)
   );

   // Gated free-running clock, period 10.
   initial forever begin
      #5;
      if (clk_en) clk = ~clk;
   end

   function automatic logic [16:0] ref_add(
      input logic [15:0] x, input logic [15:0] y, input logic ci
   );
      int unsigned s;
      s = int'(x) + int'(y) + int'(ci);
      return s[16:0];
   endfunction

   function automatic logic ref_ovf(
      input logic [15:0] x, input logic [15:0] y, input logic ci
   );
      int s;
      s = int'($signed(x)) + int'($signed(y)) + int'(ci);
      return (s > 32767) || (s < -32768);
   endfunction

   task automatic check(
      input string tag, input logic [15:0] obs, input logic [15:0] exp
   );
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Wait for the next rising edge (bounded), then settle 1 unit.
   task automatic tick();
      logic prev;
      bit   seen;
      prev = clk;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         #1;
         if (clk && !prev) seen = 1;
         prev = clk;
      end
      if (!seen) begin
         total++;
         $error("FAIL tick_timeout: observed no edge expected edge");
      end
      #1;
   endtask

   task automatic check_comb(input string tag);
      logic [16:0] r;
      r = ref_add(a, b, cin);
      check({tag, "_sum"}, sum, r[15:0]);
      check({tag, "_cout"}, 16'(cout), 16'(r[16]));
   endtask

   task automatic check_reg(input string tag,
      input logic [15:0] s, input logic co, input logic ov);
      check({tag, "_sum_q"}, sum_q, s);
      check({tag, "_cout_q"}, 16'(cout_q), 16'(co));
      check({tag, "_ovf_q"}, 16'(ovf_q), 16'(ov));
   endtask

   logic [15:0] va [6] = '{16'h158A, 16'h158A, 16'h52AF,
                          16'hB903, 16'hFFFF, 16'h7FFF};
   logic [15:0] vb [6] = '{16'h7095, 16'h7095, 16'h9A4E,
                          16'hC6BD, 16'h0000, 16'h0001};
   logic        vc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [15:0] es [6] = '{16'h861F, 16'h8620, 16'hECFD,
                          16'h7FC0, 16'h0000, 16'h8000};
   logic        ec [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic        eo [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      logic [16:0] r;
      logic [15:0] hold_s;
      logic        hold_c, hold_o, ov;

      rst_n = 1'b0;
      a = 16'h0; b = 16'h0; cin = 1'b0;
      #3;
      check_reg("reset", 16'h0, 1'b0, 1'b0);

      // Registered side stays at zero across an edge in reset.
      a = 16'h158A; b = 16'h7095;
      tick();
      check_reg("reset_hold", 16'h0, 1'b0, 1'b0);
      check_comb("reset_comb");
      rst_n = 1'b1;

      // Directed vectors with literal expectations.
      for (int i = 0; i < 6; i++) begin
         a = va[i]; b = vb[i]; cin = vc[i];
         #1;
         check($sformatf("dir%0d_sum", i), sum, es[i]);
         check($sformatf("dir%0d_cout", i), 16'(cout), 16'(ec[i]));
         tick();
         check_reg($sformatf("dir%0d", i), es[i], ec[i], eo[i]);
      end

      // Mid-cycle reset discards the registered result.
      a = 16'hB903; b = 16'hC6BD; cin = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_reg("midrst", 16'h0, 1'b0, 1'b0);
      check_comb("midrst_comb");
      tick();
      check_reg("midrst_edge", 16'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      check_reg("midrst_rel", 16'h7FC0, 1'b1, 1'b1);

      // Random vectors; mid-cycle input changes must not
      // disturb the registered outputs before the next edge.
      hold_s = sum_q; hold_c = cout_q; hold_o = ovf_q;
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         cin = 1'($urandom);
         #2;
         check_comb("rnd");
         check_reg("rnd_hold", hold_s, hold_c, hold_o);
         r = ref_add(a, b, cin);
         ov = ref_ovf(a, b, cin);
         tick();
         check_reg("rnd", r[15:0], r[16], ov);
         hold_s = r[15:0]; hold_c = r[16]; hold_o = ov;
      end

      // Clock stopped: combinational path alone tracks inputs.
      clk_en = 1'b0;
      #10;
      a = 16'($urandom); b = 16'($urandom); cin = 1'b0;
      for (int t = 0; t < 200; t += 10) begin
         if (t != 0) begin
            cin = ~cin;
            if (t % 20 == 0) b = 16'($urandom);
            if (t % 60 == 0) a = 16'($urandom);
         end
         #1;
         check_comb("noclk");
         check_reg("noclk_hold", hold_s, hold_c, hold_o);
         #9;
      end
      clk_en = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/full_adder_16bit.md
FULL_ADDER_16BIT -- requirements
Module: full_adder_16bit

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; only 16 is required to be supported.
REQ-002 Port declaration order SHALL be a, b, cin, sum, cout, clk, rst_n so five-port positional hookups stay valid; listing below is clock/reset first.
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a  input  16  operand A, unsigned or two's complement.
REQ-006 b  input  16  operand B.
REQ-007 cin  input  1  carry-in.
REQ-008 sum  output  16  combinational a+b+cin, low 16 bits.
REQ-009 cout  output  1  combinational carry-out (bit 16 of a+b+cin).
REQ-010 sum_q  output  16  registered sum.
REQ-011 cout_q  output  1  registered cout.
REQ-012 ovf_q  output  1  registered signed-overflow flag.

Function
REQ-013 {cout,sum} SHALL equal a+b+cin evaluated at 17 bits, purely combinational, zero cycle latency, no dependence on clk or rst_n.
REQ-014 Adder SHALL be a 16-stage ripple-carry chain: stage i takes a[i], b[i], carry c[i], produces sum[i], c[i+1]; c[0]=cin, cout=c[16].
REQ-015 Per stage: s = a^b^c; co = (a&b)|(a&c)|(b&c).
REQ-016 Signed overflow ovf = c[15]^c[16] (equivalently operands same sign, result sign differs).
REQ-017 On each rising clk edge with rst_n high, sum_q<=sum, cout_q<=cout, ovf_q<=ovf; latency exactly 1 cycle, new result every cycle, no handshake.
REQ-018 Inputs changing mid-cycle SHALL affect only combinational outputs until the next rising edge.
REQ-019 Wrap-around: results above 0xFFFF SHALL wrap modulo 2^16 with cout=1; no saturation.
REQ-020 X/Z on inputs need not be handled; outputs for defined inputs SHALL never be X after reset.

Reset
REQ-021 rst_n low SHALL clear sum_q, cout_q, ovf_q to 0 immediately, independent of clk.
REQ-022 Registered outputs SHALL hold 0 while rst_n is low; the first capture occurs on the first rising clk edge after rst_n rises.
REQ-023 Reset SHALL NOT affect sum or cout.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight registered result; no other state exists.

Structure
REQ-025 Shared package SHALL hold WIDTH default (16) and the reset value constant for registered outputs (all zeros).
REQ-026 One sub-module full_adder_1bit (ports a, b, cin, sum, cout) SHALL implement REQ-015 and be instantiated 16 times via generate.
REQ-027 Top level contains the carry chain wiring, overflow logic and a single output register block.

Verification
REQ-028 a=0x158A, b=0x7095, cin=0 -> sum=0x861F, cout=0; with cin=1 -> sum=0x8620, cout=0; next edge sum_q matches.
REQ-029 a=0x52AF, b=0x9A4E, cin=0 -> sum=0xECFD, cout=0, ovf_q=0 after one edge.
REQ-030 a=0xB903, b=0xC6BD, cin=0 -> sum=0x7FC0, cout=1; after edge cout_q=1, ovf_q=1.
REQ-031 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (full carry ripple); a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf_q=1.
REQ-032 Hold rst_n low between edges with valid inputs -> sum_q/cout_q/ovf_q go 0 immediately, sum/cout stay correct; release -> registered outputs update at next edge.
REQ-033 Toggle cin every 10 time units, b every 20, a every 60 over 200 units with clk unconnected -> sum/cout match a+b+cin at every change.
